// File: rtl/a_rx_serial_sampler.sv
// a_rx_serial_sampler: RS232 receive bit sampler that strobes each data bit out at mid-bit and checks the stop bit
module a_rx_serial_sampler #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic rx_i,
  output logic r_do,
  output logic r_stb,
  output logic r_fend,
  output logic r_ferr,
  output logic r_busy
);
  localparam logic [15:0] HALF_M1 = 16'((CLK_DIV >> 1) - 1);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [4:0]  LAST    = 5'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] baud_q, baud_d;
  logic [4:0]  bit_q, bit_d;
  logic        r_do_q, r_do_d;
  logic        r_stb_q, r_stb_d;
  logic        r_fend_q, r_fend_d;
  logic        r_ferr_q, r_ferr_d;
  logic        r_busy_q, r_busy_d;
  logic        rx_s;
  assign rx_s   = sync_q[1];
  assign r_do   = r_do_q;
  assign r_stb  = r_stb_q;
  assign r_fend = r_fend_q;
  assign r_ferr = r_ferr_q;
  assign r_busy = r_busy_q;
  // next-state: baud counter free-runs inside a frame and is cleared at every sample point
  always_comb begin
    sync_d   = {sync_q[0], rx_i};
    state_d  = state_q;
    baud_d   = baud_q + 16'd1;
    bit_d    = bit_q;
    r_do_d   = r_do_q;
    r_stb_d  = 1'b0;
    r_fend_d = 1'b0;
    r_ferr_d = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d  = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_q == DIV_M1) begin
          baud_d  = '0;
          r_do_d  = rx_s;
          r_stb_d = 1'b1;
          bit_d   = bit_q + 5'd1;
          state_d = (bit_q == LAST) ? STOP : DATA;
        end
      end
      STOP: begin
        if (baud_q == DIV_M1) begin
          baud_d   = '0;
          r_fend_d = rx_s;
          r_ferr_d = ~rx_s;
          state_d  = rx_s ? IDLE : WAIT_HI;
        end
      end
      WAIT_HI: begin
        baud_d  = '0;
        state_d = rx_s ? IDLE : WAIT_HI;
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
    r_busy_d = (state_d != IDLE);
  end
  // state, synchronizer and registered outputs; the synchronizer resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync_q   <= 2'b11;
      baud_q   <= '0;
      bit_q    <= '0;
      r_do_q   <= 1'b0;
      r_stb_q  <= 1'b0;
      r_fend_q <= 1'b0;
      r_ferr_q <= 1'b0;
      r_busy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      r_do_q   <= r_do_d;
      r_stb_q  <= r_stb_d;
      r_fend_q <= r_fend_d;
      r_ferr_q <= r_ferr_d;
      r_busy_q <= r_busy_d;
    end
  end
endmodule

// File: tb/tb_a_rx_serial_sampler.sv
// tb_a_rx_serial_sampler: directed and random frames checked against arithmetic frame timing
module tb_a_rx_serial_sampler;
  logic clk_ref = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic a_do, a_stb, a_fend, a_ferr, a_busy;
  logic b_do, b_stb, b_fend, b_ferr, b_busy;
  int cyc = 0, checks = 0, errors = 0, busy_cnt = 0;
  int dm_cnt = 0, dm_valid = 0;
  logic [15:0] dm_word = '0;
  logic prev_a_stb = 1'b0, prev_a_do = 1'b0, prev_b_stb = 1'b0;
  typedef struct {int d; int c; int k; logic b;} ev_t;
  ev_t mon_q[$], exp_q[$];

  a_rx_serial_sampler #(.CLK_DIV(16), .DATA_BITS(8)) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .rx_i(rx_a),
    .r_do(a_do), .r_stb(a_stb), .r_fend(a_fend), .r_ferr(a_ferr), .r_busy(a_busy));
  a_rx_serial_sampler #(.CLK_DIV(4), .DATA_BITS(16)) dut16 (
    .clk_ref(clk_ref), .rst_n(rst_n), .rx_i(rx_b),
    .r_do(b_do), .r_stb(b_stb), .r_fend(b_fend), .r_ferr(b_ferr), .r_busy(b_busy));

  always #5 clk_ref = ~clk_ref;
  always @(posedge clk_ref) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // output monitor plus a 16-bit demux model fed by the dut strobes
  always @(negedge clk_ref) begin
    if (a_stb) mon_q.push_back('{0, cyc, 0, a_do});
    if (a_fend) mon_q.push_back('{0, cyc, 1, 1'b1});
    if (a_ferr) mon_q.push_back('{0, cyc, 2, 1'b0});
    if (b_stb) mon_q.push_back('{1, cyc, 0, b_do});
    if (b_fend) mon_q.push_back('{1, cyc, 1, 1'b1});
    if (b_ferr) mon_q.push_back('{1, cyc, 2, 1'b0});
    busy_cnt += int'(a_busy);
    if (a_stb) check("a_stb_isolated", int'({prev_a_stb, a_fend, a_ferr}), 0);
    if (b_stb) check("b_stb_isolated", int'({prev_b_stb, b_fend, b_ferr}), 0);
    if (prev_a_stb && !a_stb) check("a_do_hold", int'(a_do), int'(prev_a_do));
    if (a_stb) begin
      dm_word = {a_do, dm_word[15:1]};
      dm_cnt++;
      if (dm_cnt == 16) begin
        dm_valid++;
        dm_cnt = 0;
      end
    end
    prev_a_stb = a_stb;
    prev_a_do  = a_do;
    prev_b_stb = b_stb;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk_ref);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx_a = v; else rx_b = v;
  endtask

  // expected events of one frame whose start edge is driven just after edge n
  task automatic expect_frame(input int d, input int n, input logic [15:0] data, input int nb,
                              input int div, input int nstb, input int stop_kind);
    int t0;
    t0 = n + 3 + div / 2;
    for (int k = 0; k < nstb; k++) exp_q.push_back('{d, t0 + div * (k + 1), 0, data[k]});
    if (stop_kind == 1) exp_q.push_back('{d, t0 + div * (nb + 1), 1, 1'b1});
    if (stop_kind == 2) exp_q.push_back('{d, t0 + div * (nb + 1), 2, 1'b0});
  endtask

  task automatic send(input int d, input logic [15:0] data, input int nb, input int div,
                      input int stop_len, input logic stop_val, input int gap);
    expect_frame(d, cyc, data, nb, div, nb, stop_val ? 1 : 2);
    set_rx(d, 1'b0);
    tick(div);
    for (int k = 0; k < nb; k++) begin
      set_rx(d, data[k]);
      tick(div);
    end
    set_rx(d, stop_val);
    tick(stop_len);
    set_rx(d, 1'b1);
    tick(gap);
  endtask

  task automatic compare(input string tag);
    ev_t e, m;
    tick(12);
    check({tag, "_events"}, mon_q.size(), exp_q.size());
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mon_q.pop_front();
      check({tag, "_dut"}, m.d, e.d);
      check({tag, "_cycle"}, m.c, e.c);
      check({tag, "_kind"}, m.k, e.k);
      check({tag, "_bit"}, int'(m.b), int'(e.b));
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a"}, int'({a_do, a_stb, a_fend, a_ferr, a_busy}), 0);
    check({tag, "_b"}, int'({b_do, b_stb, b_fend, b_ferr, b_busy}), 0);
  endtask

  initial begin
    int n, d, nb, div, gap;
    logic [15:0] data;
    tick(3);
    @(negedge clk_ref);
    check_idle_outputs("reset");
    tick(1);
    rst_n = 1'b1;
    tick(4);
    @(negedge clk_ref);
    check_idle_outputs("after_reset");
    tick(1);

    send(0, 16'h00A5, 8, 16, 16, 1'b1, 20);
    compare("frame_a5");

    busy_cnt = 0;
    rx_a = 1'b0;
    tick(5);
    rx_a = 1'b1;
    tick(30);
    compare("glitch");
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_busy_end", int'(a_busy), 0);

    send(0, 16'h0000, 8, 16, 40, 1'b0, 0);
    tick(2);
    @(negedge clk_ref);
    check("wait_hi_busy", int'(a_busy), 1);
    tick(1);
    @(negedge clk_ref);
    check("wait_hi_released", int'(a_busy), 0);
    tick(10);
    compare("stop_low");
    send(0, 16'h0081, 8, 16, 16, 1'b1, 10);
    compare("frame_81");

    dm_cnt = 0;
    dm_valid = 0;
    send(0, 16'h005A, 8, 16, 16, 1'b1, 0);
    send(0, 16'h003C, 8, 16, 16, 1'b1, 20);
    compare("back_to_back");
    check("demux_valid_count", dm_valid, 1);
    check("demux_word", int'(dm_word), 16'h3C5A);

    n = cyc;
    expect_frame(0, n, 16'h00FF, 8, 16, 3, 0);
    rx_a = 1'b0;
    tick(16);
    rx_a = 1'b1;
    tick(48);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ref);
      check_idle_outputs("in_reset");
      tick(1);
    end
    rst_n = 1'b1;
    tick(5);
    compare("reset_partial");
    send(0, 16'h0012, 8, 16, 16, 1'b1, 10);
    compare("frame_12");

    send(1, 16'hBEEF, 16, 4, 4, 1'b1, 10);
    compare("frame_beef");

    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(1, 0));
      data = 16'($urandom);
      nb = (d == 0) ? 8 : 16;
      div = (d == 0) ? 16 : 4;
      gap = int'($urandom_range(10, 0));
      send(d, data, nb, div, div, 1'b1, gap);
      compare("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/a_rx_serial_sampler.md
Name: a_rx_serial_sampler

Overview:
RS232 receive bit sampler, upstream of the 1-to-16 serial demux.
- Oversamples the asynchronous RX line with the system clock.
- Detects the start bit and samples each data bit at mid-bit.
- Emits each data bit with a one-cycle strobe; the strobe drives the demux's bit-enable input and the bit drives its serial data input.
- Checks the stop bit and flags framing errors.

Parameters:
CLK_DIV, 16, clk_ref cycles per bit; range 4..65535; half-bit HALF = CLK_DIV>>1
DATA_BITS, 8, data bits per frame, LSB first; range 1..16

Ports:
clk_ref  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_i  input  1  raw RS232 line, asynchronous, idle high
r_do  output  1  sampled data bit, valid while r_stb=1
r_stb  output  1  one-cycle data-bit strobe (feeds demux bit enable)
r_fend  output  1  one-cycle pulse: frame completed with valid stop bit
r_ferr  output  1  one-cycle pulse: stop bit sampled low
r_busy  output  1  high from start detect until return to IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0, synchronizer stages set to 1 (idle line). On release, first action is the next rising clk_ref.
- Synchronizer: rx_i passes through 2 flops to give rx_s (2-cycle latency). All decisions use rx_s only.
- Baud counter: 16 bit. Bit counter: 5 bit.
- IDLE:
  - r_busy=0.
  - Cycle T0 = first cycle with rx_s=0: go to START, clear baud counter, r_busy=1 from the next cycle.
- START:
  - Sample point is HALF cycles after T0 (baud counter reaches HALF-1).
  - rx_s=0 at the sample point: go to DATA, clear baud and bit counters.
  - rx_s=1 at the sample point: glitch; return to IDLE, no outputs.
- DATA:
  - Each sample point occurs CLK_DIV cycles after the previous one.
  - At a sample point: register r_do=rx_s and r_stb=1 in the following cycle only; increment the bit counter.
  - After the DATA_BITS-th sample: go to STOP.
  - r_stb is never high on two consecutive cycles.
  - r_do holds its last value when r_stb=0.
- STOP:
  - Sample point is CLK_DIV cycles after the last data sample.
  - rx_s=1: r_fend=1 for one cycle, go to IDLE. A new start bit may be detected from the cycle after.
  - rx_s=0: r_ferr=1 for one cycle, go to WAIT_HI.
- WAIT_HI:
  - Stay until rx_s=1 (break condition), then go to IDLE.
  - r_busy=1 while in WAIT_HI.
- r_fend and r_ferr are mutually exclusive. Neither is ever coincident with r_stb.
- Reset mid-frame: immediate abort, outputs 0. A partial bit sequence is not completed. Downstream demux alignment is the system's responsibility because the demux shares rst_n.
- rx_i changes between sample points are ignored; there is no majority vote.

Test Plan:
- CLK_DIV=16, frame 0xA5 (start 0, bits LSB first, stop 1) -> 8 r_stb pulses exactly 16 cycles apart; r_do = 1,0,1,0,0,1,0,1; first strobe 2+8+16+1 cycles after the rx_i falling edge; then one r_fend, no r_ferr.
- Low glitch on rx_i of 5 cycles (< HALF=8) -> no r_stb, r_fend or r_ferr; r_busy pulses briefly, then back in IDLE.
- Frame 0x00 with stop bit held low for 40 cycles -> 8 strobes with r_do=0, one r_ferr; r_busy stays 1 until rx_s returns high; then a new frame 0x81 decodes correctly.
- Back-to-back frames 0x5A then 0x3C, with no idle gap, fed into the 16-bit demux -> 16 strobes; demux data-valid asserts once with word 0x3C5A; two r_fend pulses.
- rst_n asserted low after the 3rd data bit of 0xFF, released 10 cycles later, then frame 0x12 sent -> outputs 0 during reset; afterwards exactly 8 strobes with r_do = 0,1,0,0,1,0,0,0.
- CLK_DIV=4, DATA_BITS=16, frame 0xBEEF -> 16 strobes 4 cycles apart matching LSB-first bits; one r_fend.
